// File: rtl/blur_pkg.sv
// blur_pkg: pixel type, kernel geometry and bank-rotation helpers shared by
// blur_line_buffer and gaussian_blur.
package blur_pkg;

  localparam int BLUR_KERNEL_SIZE = 3;
  localparam int BLUR_HRES_DEF    = 1280;
  localparam int BLUR_VRES_DEF    = 720;
  localparam int NUM_BANKS        = 3;

  localparam int PIX_W    = 16;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // RGB565 field bounds
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [1:0]       bank_sel_t;

  // Bank rotation is modulo 3 on a 2-bit selector.
  function automatic bank_sel_t next_bank(input bank_sel_t sel);
    return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

  function automatic bank_sel_t prev_bank(input bank_sel_t sel);
    return (sel == 2'd0) ? 2'd2 : sel - 2'd1;
  endfunction

endpackage

// File: rtl/line_bank.sv
// line_bank: simple dual-port line RAM, DEPTH x 16, read latency 2
// (registered read address, then registered read data). Contents are never reset.
module line_bank
  import blur_pkg::*;
#(
  parameter int DEPTH = BLUR_HRES_DEF,
  parameter int AW    = $clog2(BLUR_HRES_DEF)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] raddr_q;
  logic          re_q;

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds between reads so an idle bank does not toggle its output.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      raddr_q <= '0;
      re_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      re_q <= re;
      if (re) begin
        raddr_q <= raddr;
      end
      if (re_q) begin
        rdata <= mem[raddr_q];
      end
    end
  end

endmodule

// File: rtl/blur_line_buffer.sv
// blur_line_buffer: three rotating line banks presenting rows v-2, v-1, v of one
// column per accepted pixel, 2 cycles later. Option: BLUR_EDGE_REPLICATE_EN.
module blur_line_buffer
  import blur_pkg::*;
#(
  parameter int HRES        = BLUR_HRES_DEF,
  parameter int VRES        = BLUR_VRES_DEF,
  parameter int KERNEL_SIZE = BLUR_KERNEL_SIZE
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [15:0]                  pixel_data_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         data_valid_in,
  output logic [KERNEL_SIZE-1:0][15:0] line_buffer_out,
  output logic [10:0]                  hcount_out,
  output logic [9:0]                   vcount_out,
  output logic                         data_valid_out
);

  localparam int AW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(HRES - 1);
  localparam logic [HCOUNT_W-1:0] NUM_COLS = HCOUNT_W'(HRES);
  localparam logic [VCOUNT_W-1:0] LAST_ROW = VCOUNT_W'(VRES - 1);

  typedef struct packed {
    logic                valid;
    pixel_t              pix;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    bank_sel_t           sel_m1;
    bank_sel_t           sel_m2;
`ifdef BLUR_EDGE_REPLICATE_EN
    logic                top_edge;
    logic                bot_edge;
`endif
  } stage_t;

  bank_sel_t            wr_sel;
  logic                 accept;
  stage_t               stage_d;
  stage_t               s1;
  stage_t               s2;
  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS-1:0] bank_re;
  pixel_t               bank_rdata [NUM_BANKS];
  pixel_t               row_m1;
  pixel_t               row_m2;

  // A pixel presented while reset is held is dropped, not written.
  assign accept = data_valid_in && (hcount_in < NUM_COLS) && !rst_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_sel <= 2'd0;
    end else if (accept && (hcount_in == LAST_COL)) begin
      wr_sel <= next_bank(wr_sel);
    end
  end

  // The bank being written is never read in the same cycle.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_we[k] = accept && (wr_sel == 2'(k));
      bank_re[k] = accept && (wr_sel != 2'(k));
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    line_bank #(
      .DEPTH (HRES),
      .AW    (AW)
    ) u_bank (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .we     (bank_we[k]),
      .waddr  (hcount_in[AW-1:0]),
      .wdata  (pixel_data_in),
      .re     (bank_re[k]),
      .raddr  (hcount_in[AW-1:0]),
      .rdata  (bank_rdata[k])
    );
  end

  always_comb begin
    stage_d        = '0;
    stage_d.valid  = accept;
    stage_d.pix    = pixel_data_in;
    stage_d.hcount = hcount_in;
    stage_d.vcount = (vcount_in == '0) ? LAST_ROW : vcount_in - 10'd1;
    stage_d.sel_m1 = prev_bank(wr_sel);
    stage_d.sel_m2 = prev_bank(prev_bank(wr_sel));
`ifdef BLUR_EDGE_REPLICATE_EN
    stage_d.top_edge = (vcount_in == 10'd1);
    stage_d.bot_edge = (vcount_in == 10'd0);
`endif
  end

  // Two stages match the bank read latency; payload holds across gaps.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (accept) begin
        s1 <= stage_d;
      end else begin
        s1.valid <= 1'b0;
      end
      if (s1.valid) begin
        s2 <= s1;
      end else begin
        s2.valid <= 1'b0;
      end
    end
  end

  function automatic pixel_t pick_bank(input bank_sel_t sel, input pixel_t b0,
                                       input pixel_t b1, input pixel_t b2);
    case (sel)
      2'd0:    return b0;
      2'd1:    return b1;
      default: return b2;
    endcase
  endfunction

  always_comb begin
    row_m1 = pick_bank(s2.sel_m1, bank_rdata[0], bank_rdata[1], bank_rdata[2]);
    row_m2 = pick_bank(s2.sel_m2, bank_rdata[0], bank_rdata[1], bank_rdata[2]);
    line_buffer_out    = '0;
    line_buffer_out[0] = row_m2;
    line_buffer_out[1] = row_m1;
    line_buffer_out[2] = s2.pix;
`ifdef BLUR_EDGE_REPLICATE_EN
    // Rows outside the frame are replaced by the centre row.
    if (s2.top_edge) begin
      line_buffer_out[0] = row_m1;
    end
    if (s2.bot_edge) begin
      line_buffer_out[2] = row_m1;
    end
`endif
  end

  assign hcount_out     = s2.hcount;
  assign vcount_out     = s2.vcount;
  assign data_valid_out = s2.valid;

endmodule

// File: tb/tb_blur_line_buffer.sv
// tb_blur_line_buffer: directed line streams for blur_line_buffer (HRES=8) with
// a row-bank reference model feeding an expected queue.
module tb_blur_line_buffer;

  localparam int HRES = 8;
  localparam int VRES = 720;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [15:0]      pixel_data_in = '0;
  logic [10:0]      hcount_in = '0;
  logic [9:0]       vcount_in = '0;
  logic             data_valid_in = 1'b0;
  logic [2:0][15:0] line_buffer_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic             data_valid_out;

  int n_checks = 0;
  int n_errors = 0;

  blur_line_buffer #(
    .HRES        (HRES),
    .VRES        (VRES),
    .KERNEL_SIZE (3)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pixel_data_in   (pixel_data_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .data_valid_in   (data_valid_in),
    .line_buffer_out (line_buffer_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .data_valid_out  (data_valid_out)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int v, input int h);
    return {5'(v), 6'(h), 5'd0};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic        k0;
    logic        k1;
    logic        k2;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      model_mem [3][HRES];
  logic [HRES-1:0]  model_wr  [3];
  logic [1:0]       m_sel;
  logic [1:0]       vpipe;
  logic             m_acc;

  assign m_acc = data_valid_in && (hcount_in < 11'(HRES));

  initial begin
    for (int b = 0; b < 3; b++) model_wr[b] = '0;
  end

  function automatic exp_t make_exp();
    exp_t e;
    int   b1, b0, a;
    b1 = (int'(m_sel) + 2) % 3;
    b0 = (int'(m_sel) + 1) % 3;
    a  = int'(hcount_in[2:0]);
    e.r2 = pixel_data_in;
    e.k2 = 1'b1;
    e.r1 = model_mem[b1][a];
    e.k1 = model_wr[b1][a];
    e.r0 = model_mem[b0][a];
    e.k0 = model_wr[b0][a];
    e.h  = hcount_in;
    e.v  = (vcount_in == 10'd0) ? 10'(VRES - 1) : vcount_in - 10'd1;
`ifdef BLUR_EDGE_REPLICATE_EN
    if (vcount_in == 10'd1) begin
      e.r0 = e.r1;
      e.k0 = e.k1;
    end
    if (vcount_in == 10'd0) begin
      e.r2 = e.r1;
      e.k2 = e.k1;
    end
`endif
    return e;
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vpipe <= 2'b00;
      m_sel <= 2'd0;
      exp_q.delete();
    end else begin
      vpipe <= {vpipe[0], m_acc};
      if (m_acc) begin
        exp_q.push_back(EXP_W'(make_exp()));
        model_mem[m_sel][hcount_in[2:0]] <= pixel_data_in;
        model_wr[m_sel][hcount_in[2:0]]  <= 1'b1;
        if (hcount_in == 11'(HRES - 1)) m_sel <= (m_sel == 2'd2) ? 2'd0 : m_sel + 2'd1;
      end
    end
  end

  always @(negedge clk_in) begin
    exp_t e;
    check("dv", data_valid_out, vpipe[1]);
    if (data_valid_out && vpipe[1]) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 1, 0);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("hcount_out", hcount_out, e.h);
        check("vcount_out", vcount_out, e.v);
        if (e.k2) check("row_v", line_buffer_out[2], e.r2);
        if (e.k1) check("row_v1", line_buffer_out[1], e.r1);
        if (e.k0) check("row_v2", line_buffer_out[0], e.r0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int v, input int h, input logic vld);
    vcount_in     = 10'(v);
    hcount_in     = 11'(h);
    pixel_data_in = pix(v, h);
    data_valid_in = vld;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    data_valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic feed_line(input int v, input logic toggle);
    for (int h = 0; h < HRES; h++) begin
      drive(v, h, 1'b1);
      if (toggle) drive(v, h, 1'b0);
    end
  endtask

  // Row v fed back-to-back with a directed check of the h=3 column.
  task automatic feed_line_chk(input int v, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2);
    for (int h = 0; h <= 4; h++) drive(v, h, 1'b1);
    check("dir_valid", data_valid_out, 1'b1);
    check("dir_row0", line_buffer_out[0], e0);
    check("dir_row1", line_buffer_out[1], e1);
    check("dir_row2", line_buffer_out[2], e2);
    check("dir_hcount", hcount_out, 11'd3);
    check("dir_vcount", vcount_out, 10'(v - 1));
    for (int h = 5; h < HRES; h++) drive(v, h, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2 rst_in = 1'b1;
    #1;
    check("rst_dv", data_valid_out, 1'b0);
    check("rst_lbo", line_buffer_out, 48'd0);
    check("rst_hcount", hcount_out, 11'd0);
    check("rst_vcount", vcount_out, 10'd0);
    check("rst_wr_sel", dut.wr_sel, 2'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;

    // rows 0..2 continuous
    feed_line(0, 1'b0);
    check("wr_sel_l1", dut.wr_sel, 2'd1);
    feed_line(1, 1'b0);
    check("wr_sel_l2", dut.wr_sel, 2'd2);
    feed_line_chk(2, 16'h0060, 16'h0860, 16'h1060);
    check("wr_sel_l3", dut.wr_sel, 2'd0);

    // same rows with valid toggling every other cycle
    feed_line(0, 1'b1);
    feed_line(1, 1'b1);
    feed_line(2, 1'b1);
    check("wr_sel_tog", dut.wr_sel, 2'd0);

    // fourth line overwrites bank 0
    feed_line_chk(3, 16'h0860, 16'h1060, 16'h1860);
    check("wr_sel_l4", dut.wr_sel, 2'd1);
    idle(3);

    // out-of-range column: no write, no output
    drive(3, HRES + 2, 1'b1);
    idle(3);
    check("oob_dv", data_valid_out, 1'b0);
    check("oob_bank", dut.g_bank[1].u_bank.mem[2], 16'h0840);
    check("oob_wr_sel", dut.wr_sel, 2'd1);

    // reset pulse mid-line at h=4
    for (int h = 0; h <= 3; h++) drive(4, h, 1'b1);
    vcount_in     = 10'd4;
    hcount_in     = 11'd4;
    pixel_data_in = pix(4, 4);
    data_valid_in = 1'b1;
    rst_in        = 1'b1;
    #1;
    check("mid_rst_dv", data_valid_out, 1'b0);
    check("mid_rst_lbo", line_buffer_out, 48'd0);
    check("mid_rst_hcount", hcount_out, 11'd0);
    check("mid_rst_vcount", vcount_out, 10'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    data_valid_in = 1'b0;
    check("post_rst_wr_sel", dut.wr_sel, 2'd0);
    drive(5, 0, 1'b1);
    check("post_rst_bank0", dut.g_bank[0].u_bank.mem[0], 16'h2800);
    idle(3);

    // frame edges: vcount_in=1 then vcount_in=0
    drive(1, 0, 1'b1);
    drive(0, 0, 1'b1);
    idle(1);
    check("edge_dv", data_valid_out, 1'b1);
    check("edge_vcount", vcount_out, 10'd719);
    check("edge_hcount", hcount_out, 11'd0);
    idle(3);

    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/blur_line_buffer.md
BLUR_LINE_BUFFER -- requirements
Module: blur_line_buffer

Interface
REQ-001 Parameter HRES, default 1280, active pixels per line.
REQ-002 Parameter VRES, default 720, active lines per frame.
REQ-003 Parameter KERNEL_SIZE, default 3, rows presented per output; only 3 is supported.
REQ-004 clk_in  input  1  single clock; all logic on posedge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 pixel_data_in  input  16  RGB565 pixel (R[15:11], G[10:5], B[4:0]).
REQ-007 hcount_in  input  11  column of pixel_data_in.
REQ-008 vcount_in  input  10  row of pixel_data_in.
REQ-009 data_valid_in  input  1  pixel qualifier; one pixel per cycle max.
REQ-010 line_buffer_out  output  KERNEL_SIZE x 16  vertical column: [0]=row v-2, [1]=row v-1, [2]=row v (same column).
REQ-011 hcount_out  output  11  column of line_buffer_out.
REQ-012 vcount_out  output  10  centre row of line_buffer_out.
REQ-013 data_valid_out  output  1  qualifier for the three outputs above.

Function
REQ-014 The block SHALL hold three line banks of HRES x 16; a 2-bit wr_sel (0..2) selects the bank written.
REQ-015 Every accepted pixel (data_valid_in=1, hcount_in<HRES) SHALL be written to bank wr_sel at address hcount_in, while the same address is read from banks (wr_sel-1) mod 3 (row v-1) and (wr_sel-2) mod 3 (row v-2).
REQ-016 Pixels with hcount_in>=HRES SHALL be discarded: no write, no output.
REQ-017 wr_sel SHALL advance (2->0 wrap) in the cycle after an accepted pixel with hcount_in=HRES-1; no other event advances it.
REQ-018 Latency SHALL be exactly 2 cycles from accepted input to data_valid_out=1; pixel_data_in, hcount_in, and the bank selections SHALL be delayed in lockstep so the three rows stay column-aligned.
REQ-019 hcount_out SHALL equal the delayed hcount_in.
REQ-020 vcount_out SHALL equal vcount_in-1, with vcount_in=0 mapping to VRES-1.
REQ-021 data_valid_out SHALL be high for exactly one cycle per accepted pixel.
REQ-022 Gaps in data_valid_in SHALL propagate unchanged.
REQ-023 Back-to-back pixels SHALL sustain 1 pixel/cycle.
REQ-024 Read-before-write: a read and write to the same bank never occur in one cycle, by construction of REQ-015.

Reset
REQ-025 On rst_in: data_valid_out=0, line_buffer_out=0, hcount_out=0, vcount_out=0, wr_sel=0, and all pipeline valid bits cleared, asynchronously.
REQ-026 Bank contents SHALL NOT be cleared.
REQ-027 Reset asserted mid-line SHALL drop in-flight pixels (no data_valid_out).
REQ-028 The first accepted pixel after release SHALL go to bank 0.

Configuration
REQ-029 Macro BLUR_EDGE_REPLICATE_EN.
- Defined: when vcount_in=1 (centre row 0), line_buffer_out[0] SHALL be replaced by line_buffer_out[1].
- Defined: when vcount_in=0 (centre row VRES-1), line_buffer_out[2] SHALL be replaced by line_buffer_out[1].
- Not defined: raw bank data is output in both cases; no extra logic is present.

Structure
REQ-030 Package blur_pkg SHALL hold KERNEL_SIZE, default HRES/VRES, the pixel_t (16-bit RGB565) typedef, and the R/G/B field bounds; gaussian_blur shares it.
REQ-031 Sub-module line_bank SHALL implement one simple dual-port BRAM, HRES x 16, read latency 2 (registered address + output register); it is instantiated 3 times.

Verification
REQ-032 Rows 0..2 of HRES=8, each pixel = {vcount[4:0], 6'(hcount), 5'd0}, continuous valid -> row 2, h=3 outputs [0]=row0 h3, [1]=row1 h3, [2]=row2 h3; vcount_out=1, hcount_out=3, 2 cycles after input.
REQ-033 Same stream with data_valid_in toggling every other cycle -> data_valid_out toggles identically, delayed 2 cycles; data is unchanged from REQ-032.
REQ-034 Four lines fed -> wr_sel sequence 0,1,2,0; line 3 data overwrites bank 0; output at v=3 shows rows 1,2,3.
REQ-035 Pixel with hcount_in=HRES+2 and valid=1 -> no write (bank readback unchanged), data_valid_out stays 0.
REQ-036 rst_in pulsed 1 cycle mid-line at h=4 -> outputs are 0 within the same cycle; no valid for h=3,4; next pixel is written to bank 0.
REQ-037 With BLUR_EDGE_REPLICATE_EN defined, vcount_in=1, h=0 -> line_buffer_out[0]==line_buffer_out[1]; vcount_in=0 -> [2]==[1], vcount_out=VRES-1.
